// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the shared RV32I datapath.
// master = controller (drives selects/enables), slave = datapath side.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       opcode;
    logic             bcond;
    logic             mem_ready;
    logic [31:0]      ecall_arg;
    logic             pc_write;
    logic             pc_write_cond;
    logic             pc_source;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic [1:0]       wb_sel;
    logic             reg_write;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic             is_halted;
    logic             retire;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        input  opcode, bcond, mem_ready, ecall_arg,
        output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, wb_sel, reg_write, alu_src_a, alu_src_b, alu_op,
               is_halted, retire, retired_cnt
    );

    modport slave (
        output opcode, bcond, mem_ready, ecall_arg,
        input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
               ir_write, wb_sel, reg_write, alu_src_a, alu_src_b, alu_op,
               is_halted, retire, retired_cnt
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main IF/ID/EX/MEM/WB control FSM for the multi-cycle RV32I core, with halting ECALL and retire counter.
// Latency: Moore outputs same cycle as state; retire/retired_cnt update one cycle after the retiring state.
// Backpressure: IF and MEM hold (request stable) until mem_ready; no other stalls.
module multicycle_ctrl #(
    parameter int HALT_CODE = 10,
    parameter int CNT_W     = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    multicycle_ctrl_if.master bus
);
    localparam logic [6:0] OP_ARITH     = 7'b0110011;
    localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_ECALL     = 7'b1110011;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_BRANCH = 2'd1;
    localparam logic [1:0] ALU_FUNCT  = 2'd2;

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

    state_t           state_q, state_d;
    logic             retire_now;
    logic             retire_q;
    logic [CNT_W-1:0] cnt_q;

    logic       pc_write_c, pc_write_cond_c, ir_write_c, reg_write_c;
    logic       mem_read_c, mem_write_c, pc_source_c, i_or_d_c;
    logic [1:0] wb_sel_c, alu_src_a_c, alu_src_b_c, alu_op_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IF;
            retire_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            retire_q <= retire_now;
            if (retire_now)
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_d         = state_q;
        retire_now      = 1'b0;
        pc_write_c      = 1'b0;
        pc_write_cond_c = 1'b0;
        ir_write_c      = 1'b0;
        reg_write_c     = 1'b0;
        mem_read_c      = 1'b0;
        mem_write_c     = 1'b0;
        pc_source_c     = 1'b0;
        i_or_d_c        = 1'b0;
        wb_sel_c        = 2'd0;
        alu_src_a_c     = 2'd0;
        alu_src_b_c     = 2'd0;
        alu_op_c        = ALU_ADD;

        case (state_q)
            S_IF: begin
                // PC+4 is written back together with the IR latch once the fetch lands
                mem_read_c  = 1'b1;
                alu_src_b_c = 2'd1;
                ir_write_c  = bus.mem_ready;
                pc_write_c  = bus.mem_ready;
                if (bus.mem_ready)
                    state_d = S_ID;
            end
            S_ID: begin
                alu_src_a_c = 2'd2;
                alu_src_b_c = 2'd2;
                case (bus.opcode)
                    OP_ECALL: begin
                        if (bus.ecall_arg == 32'(HALT_CODE)) begin
                            state_d = S_HALT;
                        end else begin
                            state_d    = S_IF;
                            retire_now = 1'b1;
                        end
                    end
                    OP_JAL: state_d = S_WB;
                    OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR:
                        state_d = S_EX;
                    default: begin
                        state_d    = S_IF;
                        retire_now = 1'b1;
                    end
                endcase
            end
            S_EX: begin
                alu_src_a_c = 2'd1;
                case (bus.opcode)
                    OP_ARITH: begin
                        alu_op_c = ALU_FUNCT;
                        state_d  = S_WB;
                    end
                    OP_ARITH_IMM: begin
                        alu_src_b_c = 2'd2;
                        alu_op_c    = ALU_FUNCT;
                        state_d     = S_WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_b_c = 2'd2;
                        state_d     = S_MEM;
                    end
                    OP_JALR: begin
                        alu_src_b_c = 2'd2;
                        state_d     = S_WB;
                    end
                    OP_BRANCH: begin
                        alu_op_c        = ALU_BRANCH;
                        pc_write_cond_c = 1'b1;
                        pc_source_c     = 1'b1;
                        state_d         = S_IF;
                        retire_now      = 1'b1;
                    end
                    default: state_d = S_IF;
                endcase
            end
            S_MEM: begin
                i_or_d_c    = 1'b1;
                mem_write_c = (bus.opcode == OP_STORE);
                mem_read_c  = (bus.opcode != OP_STORE);
                if (bus.mem_ready) begin
                    if (bus.opcode == OP_STORE) begin
                        state_d    = S_IF;
                        retire_now = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_write_c = 1'b1;
                state_d     = S_IF;
                retire_now  = 1'b1;
                if (bus.opcode == OP_LOAD) begin
                    wb_sel_c = 2'd1;
                end else if (bus.opcode == OP_JAL || bus.opcode == OP_JALR) begin
                    // link value comes from PC, which already advanced to oldPC+4 in IF
                    wb_sel_c    = 2'd2;
                    pc_write_c  = 1'b1;
                    pc_source_c = 1'b1;
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // Enables are masked by reset_n so an in-flight access dies with the reset edge
    assign bus.pc_write      = pc_write_c      & reset_n;
    assign bus.pc_write_cond = pc_write_cond_c & reset_n;
    assign bus.ir_write      = ir_write_c      & reset_n;
    assign bus.reg_write     = reg_write_c     & reset_n;
    assign bus.mem_read      = mem_read_c      & reset_n;
    assign bus.mem_write     = mem_write_c     & reset_n;
    assign bus.pc_source     = pc_source_c;
    assign bus.i_or_d        = i_or_d_c;
    assign bus.wb_sel        = wb_sel_c;
    assign bus.alu_src_a     = alu_src_a_c;
    assign bus.alu_src_b     = alu_src_b_c;
    assign bus.alu_op        = alu_op_c;
    assign bus.is_halted     = (state_q == S_HALT);
    assign bus.retire        = retire_q;
    assign bus.retired_cnt   = cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Random-program bench for multicycle_ctrl: per-instruction signatures from an ISA-level CPI/effect table,
// checked by a negedge monitor whenever an instruction retires or the core halts.
module tb_multicycle_ctrl;
    localparam int CNT_W = 8;
    localparam int LIMIT = 20000;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_ECALL  = 7'b1110011;

    typedef struct {
        logic [6:0] op;
        int cpi, rw, wb, pcw, pcc, pcsrc, memr, memw, alu2, irw, cnt;
        bit halt;
    } rec_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();
    multicycle_ctrl #(.HALT_CODE(10), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.master)
    );

    int   checks = 0;
    int   errors = 0;
    rec_t exp_q[$];
    int   model_cnt = 0;
    int   n_issued = 0;
    int   n_target = 0;
    bit   halt_seen = 0;
    bit   mr_mode = 0;
    bit   force_vld = 0;
    logic [6:0] force_op = '0;
    logic [6:0] ops[10];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Architectural effect of one instruction with zero-wait memory
    function automatic rec_t model(input logic [6:0] op, input logic [31:0] arg);
        rec_t r;
        r = '{default: 0};
        r.op = op; r.irw = 1; r.pcw = 1; r.memr = 1;
        case (op)
            OP_R, OP_I: begin r.cpi = 4; r.rw = 1; r.alu2 = 1; end
            OP_LOAD:    begin r.cpi = 5; r.rw = 1; r.wb = 1; r.memr = 2; end
            OP_STORE:   begin r.cpi = 4; r.memw = 1; end
            OP_BRANCH:  begin r.cpi = 3; r.pcc = 1; r.pcsrc = 1; end
            OP_JAL:     begin r.cpi = 3; r.rw = 1; r.wb = 2; r.pcw = 2; r.pcsrc = 1; end
            OP_JALR:    begin r.cpi = 4; r.rw = 1; r.wb = 2; r.pcw = 2; r.pcsrc = 1; end
            OP_ECALL:   begin r.cpi = 2; r.halt = (arg == 32'd10); end
            default:    r.cpi = 2;
        endcase
        return r;
    endfunction

    task automatic issue_next();
        logic [6:0]  op;
        logic [31:0] arg;
        rec_t        r;
        if (force_vld) begin
            op = force_op;
            force_vld = 0;
            arg = 32'd10;
        end else if (n_issued == n_target) begin
            op = OP_ECALL;
            arg = 32'd10;
        end else begin
            op = ops[$urandom_range(0, 9)];
            if (op == OP_ECALL) begin
                arg = 32'($urandom_range(0, 40));
                if (arg == 32'd10) arg = 32'd3;
            end else begin
                arg = ($urandom_range(0, 1) == 1) ? 32'd10 : 32'($urandom);
            end
        end
        n_issued++;
        bus.opcode = op;
        bus.ecall_arg = arg;
        r = model(op, arg);
        if (!r.halt) begin
            model_cnt = (model_cnt + 1) % (1 << CNT_W);
            r.cnt = model_cnt;
        end
        exp_q.push_back(r);
    endtask

    // One clock: peek whether IR latches at the coming edge, then present the next instruction
    task automatic cycle();
        bit fetch;
        @(negedge clk);
        fetch = (bus.ir_write === 1'b1);
        @(posedge clk);
        #1;
        if (fetch) issue_next();
        if (mr_mode) bus.mem_ready = !bus.mem_write;
        else         bus.mem_ready = ($urandom_range(0, 3) != 0);
        bus.bcond = 1'($urandom_range(0, 1));
    endtask

    task automatic run_until_halt();
        int cyc = 0;
        while (!halt_seen && cyc < LIMIT) begin
            cycle();
            cyc++;
        end
        chk("halt_reached", int'(halt_seen), 1);
    endtask

    // Monitor: accumulate per-cycle activity, close a record on retire pulse or halt entry
    initial begin : monitor
        rec_t acc, e;
        bit   stall;
        acc = '{default: 0};
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                acc = '{default: 0};
                halt_seen = 0;
            end else if (!halt_seen) begin
                if (bus.retire || bus.is_halted) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_completion", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("halt_kind op=%b", e.op), int'(bus.is_halted), int'(e.halt));
                        chk($sformatf("cpi op=%b", e.op), acc.cpi, e.cpi);
                        chk($sformatf("reg_write op=%b", e.op), acc.rw, e.rw);
                        chk($sformatf("wb_sel op=%b", e.op), acc.wb, e.wb);
                        chk($sformatf("pc_write op=%b", e.op), acc.pcw, e.pcw);
                        chk($sformatf("pc_write_cond op=%b", e.op), acc.pcc, e.pcc);
                        chk($sformatf("pc_source op=%b", e.op), acc.pcsrc, e.pcsrc);
                        chk($sformatf("mem_read op=%b", e.op), acc.memr, e.memr);
                        chk($sformatf("mem_write op=%b", e.op), acc.memw, e.memw);
                        chk($sformatf("alu_funct op=%b", e.op), acc.alu2, e.alu2);
                        chk($sformatf("ir_write op=%b", e.op), acc.irw, e.irw);
                        if (bus.retire)
                            chk($sformatf("retired_cnt op=%b", e.op), int'(bus.retired_cnt), e.cnt);
                    end
                    acc = '{default: 0};
                    if (bus.is_halted) halt_seen = 1;
                end
                if (!bus.is_halted) begin
                    stall = (bus.mem_read || bus.mem_write) && !bus.mem_ready;
                    if (!stall) acc.cpi++;
                    if (bus.reg_write) begin acc.rw++; acc.wb = int'(bus.wb_sel); end
                    if (bus.pc_write) acc.pcw++;
                    if (bus.pc_write_cond) acc.pcc++;
                    if ((bus.pc_write || bus.pc_write_cond) && bus.pc_source) acc.pcsrc++;
                    if (bus.mem_read && bus.mem_ready) acc.memr++;
                    if (bus.mem_write && bus.mem_ready) acc.memw++;
                    if (bus.alu_op == 2'd2) acc.alu2++;
                    if (bus.ir_write) acc.irw++;
                end
            end
        end
    end

    initial begin : driver
        int stall_n;
        int cyc;
        ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL, 7'b0110111, 7'b1111111};
        reset_n = 1'b0;
        bus.opcode = OP_I;
        bus.ecall_arg = '0;
        bus.bcond = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_read", int'(bus.mem_read), 0);
        chk("rst_pc_write", int'(bus.pc_write), 0);
        chk("rst_ir_write", int'(bus.ir_write), 0);
        chk("rst_reg_write", int'(bus.reg_write), 0);
        chk("rst_mem_write", int'(bus.mem_write), 0);
        chk("rst_pc_write_cond", int'(bus.pc_write_cond), 0);
        chk("rst_retired_cnt", int'(bus.retired_cnt), 0);
        chk("rst_is_halted", int'(bus.is_halted), 0);
        chk("rst_retire", int'(bus.retire), 0);

        // Random program long enough to wrap the counter, ended by a halting ECALL
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        chk("if_mem_read", int'(bus.mem_read), 1);
        chk("if_i_or_d", int'(bus.i_or_d), 0);
        chk("if_alu_src_b", int'(bus.alu_src_b), 1);
        n_issued = 0;
        n_target = 300;
        run_until_halt();

        repeat (25) begin
            @(negedge clk);
            chk("halt_sticky", int'(bus.is_halted), 1);
            chk("halt_no_retire", int'(bus.retire), 0);
            chk("halt_no_fetch", int'(bus.mem_read), 0);
        end
        chk("halt_retired_cnt", int'(bus.retired_cnt), model_cnt);
        chk("halt_queue_empty", exp_q.size(), 0);

        @(posedge clk);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        #1;
        chk("rst2_retired_cnt", int'(bus.retired_cnt), 0);
        chk("rst2_is_halted", int'(bus.is_halted), 0);
        repeat (2) @(posedge clk);

        // Store held in MEM by a slow memory, then reset lands mid-access
        #1;
        mr_mode = 1;
        force_vld = 1;
        force_op = OP_STORE;
        bus.mem_ready = 1'b1;
        reset_n = 1'b1;
        stall_n = 0;
        cyc = 0;
        while (stall_n < 3 && cyc < 100) begin
            cycle();
            cyc++;
            if (bus.mem_write === 1'b1) stall_n++;
        end
        chk("store_stall_cycles", stall_n, 3);
        chk("store_i_or_d", int'(bus.i_or_d), 1);
        reset_n = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        #1;
        chk("store_rst_mem_write", int'(bus.mem_write), 0);
        chk("store_rst_reg_write", int'(bus.reg_write), 0);
        chk("store_rst_cnt", int'(bus.retired_cnt), 0);
        repeat (2) @(posedge clk);
        #1;
        mr_mode = 0;
        bus.mem_ready = 1'b1;
        reset_n = 1'b1;
        #1;
        chk("rel_if_mem_read", int'(bus.mem_read), 1);
        chk("rel_retired_cnt", int'(bus.retired_cnt), 0);
        n_issued = 0;
        n_target = 40;
        run_until_halt();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
